// File: rtl/mem_access_unit_if.sv
// Request/response handshake of the core data port plus the beat signals to the data RAM.
// The unit takes the slave view; the core and RAM together take the master view.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_size, mem_we, mem_re
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_size, mem_we, mem_re
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator: region check, split of misaligned accesses into aligned RAM beats,
// and sign/zero extension of load data with a one-cycle response pulse.
module mem_access_unit #(
    parameter logic [15:0] MEM_ADDR = 16'h1000
) (
    input logic              clock,
    input logic              reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StRd0, StRd1, StWr, StWrb, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, w0_q;
    logic [23:0] w1_q;
    logic [1:0]  size_q, idx_q;
    logic        we_q, signed_q, err_q, cross_q, active_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [1:0]  mem_size_q;

    logic        accept, req_err, req_cross, req_aligned, last_byte;
    logic [31:0] load_word, load_data;
    logic [7:0]  wbyte;

    // Size codes 0/1/3 equal n-1, so off+size > 3 means the access spills into the next word.
    // Leaving the region requires that spill from the last word of the 64 KiB window.
    always_comb begin
        accept      = bus.req_valid && bus.req_ready;
        req_cross   = ({1'b0, bus.req_addr[1:0]} + {1'b0, bus.req_size}) > 3'd3;
        req_err     = (bus.req_size == 2'd2) || (bus.req_addr[31:16] != MEM_ADDR) ||
                      ((&bus.req_addr[15:2]) && req_cross);
        req_aligned = (bus.req_addr[1:0] & bus.req_size) == 2'd0;
        last_byte   = idx_q == size_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err)           state_d = StResp;
                    else if (!bus.req_we)  state_d = StRd0;
                    else if (req_aligned)  state_d = StWr;
                    else                   state_d = StWrb;
                end
            end
            StRd0:       state_d = cross_q ? StRd1 : StResp;
            StRd1, StWr: state_d = StResp;
            StWrb:       state_d = last_byte ? StResp : StWrb;
            StResp:      state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            err_q       <= 1'b0;
            cross_q     <= 1'b0;
            idx_q       <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            active_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
        end else begin
            active_q    <= 1'b1;
            mem_addr_q  <= bus.mem_addr;
            mem_wdata_q <= bus.mem_wdata;
            mem_size_q  <= bus.mem_size;
            if (accept) begin
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                size_q   <= bus.req_size;
                we_q     <= bus.req_we;
                signed_q <= bus.req_signed;
                err_q    <= req_err;
                cross_q  <= req_cross;
                idx_q    <= '0;
                w1_q     <= '0;
            end
            if (state_q == StRd0) w0_q <= bus.mem_rdata;
            // The top byte of the second word can never land inside a 4-byte result.
            if (state_q == StRd1) w1_q <= bus.mem_rdata[23:0];
            if (state_q == StWrb) idx_q <= idx_q + 2'd1;
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    load_word = w0_q;
            2'd1:    load_word = {w1_q[7:0], w0_q[31:8]};
            2'd2:    load_word = {w1_q[15:0], w0_q[31:16]};
            default: load_word = {w1_q[23:0], w0_q[31:24]};
        endcase
        case (size_q)
            2'd0:    load_data = {{24{signed_q & load_word[7]}}, load_word[7:0]};
            2'd1:    load_data = {{16{signed_q & load_word[15]}}, load_word[15:0]};
            default: load_data = load_word;
        endcase
        case (idx_q)
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase
    end

    // Bus outputs hold their previous value whenever no beat is issued.
    always_comb begin
        bus.req_ready  = (state_q == StIdle) && active_q;
        bus.resp_valid = state_q == StResp;
        bus.resp_err   = (state_q == StResp) && err_q;
        bus.resp_rdata = ((state_q == StResp) && !err_q && !we_q) ? load_data : 32'd0;
        bus.mem_re     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = mem_addr_q;
        bus.mem_wdata  = mem_wdata_q;
        bus.mem_size   = mem_size_q;
        unique case (state_q)
            StRd0: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = {addr_q[31:2], 2'b00};
                bus.mem_size = 2'd3;
            end
            StRd1: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = {addr_q[31:2], 2'b00} + 32'd4;
                bus.mem_size = 2'd3;
            end
            StWr: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_size  = size_q;
                bus.mem_wdata = wdata_q;
            end
            StWrb: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr_q + {30'd0, idx_q};
                bus.mem_size  = 2'd0;
                bus.mem_wdata = {4{wbyte}};
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: RAM model on the bus, byte-level reference memory,
// directed cases followed by randomized loads/stores.
module tb_mem_access_unit;
    logic clock = 1'b0;
    logic reset;
    logic load_ram;

    mem_access_unit_if bus ();

    mem_access_unit #(.MEM_ADDR(16'h1000)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    logic [7:0]  ram     [65536];
    logic [7:0]  ref_mem [65536];
    logic [31:0] rlog    [4096];
    logic [31:0] wlog_addr [4096];
    logic [7:0]  wlog_data [4096];
    logic [1:0]  wlog_size [4096];
    logic [31:0] re_cnt = 0;
    logic [31:0] we_cnt = 0;
    logic [31:0] both_cnt = 0;

    int checks = 0;
    int errors = 0;

    int          t_lat;
    logic [31:0] t_rdata;
    logic        t_err;
    logic [31:0] t_rbase, t_wbase;

    function automatic logic [7:0] init_byte(input int i);
        logic [31:0] h;
        h = i * 32'h9E3779B1;
        return h[23:16];
    endfunction

    // RAM model: read data appears on negedge, writes use right-justified data.
    always @(negedge clock) begin
        if (load_ram) begin
            for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
        end
        if (bus.mem_re) begin
            bus.mem_rdata <= {ram[{bus.mem_addr[15:2], 2'd3}], ram[{bus.mem_addr[15:2], 2'd2}],
                              ram[{bus.mem_addr[15:2], 2'd1}], ram[{bus.mem_addr[15:2], 2'd0}]};
            rlog[re_cnt[11:0]] <= bus.mem_addr;
            re_cnt <= re_cnt + 1;
        end
        if (bus.mem_we) begin
            case (bus.mem_size)
                2'd0: ram[bus.mem_addr[15:0]] <= bus.mem_wdata[7:0];
                2'd1: begin
                    ram[bus.mem_addr[15:0]]         <= bus.mem_wdata[7:0];
                    ram[bus.mem_addr[15:0] + 16'd1] <= bus.mem_wdata[15:8];
                end
                default: begin
                    ram[{bus.mem_addr[15:2], 2'd0}] <= bus.mem_wdata[7:0];
                    ram[{bus.mem_addr[15:2], 2'd1}] <= bus.mem_wdata[15:8];
                    ram[{bus.mem_addr[15:2], 2'd2}] <= bus.mem_wdata[23:16];
                    ram[{bus.mem_addr[15:2], 2'd3}] <= bus.mem_wdata[31:24];
                end
            endcase
            wlog_addr[we_cnt[11:0]] <= bus.mem_addr;
            wlog_data[we_cnt[11:0]] <= bus.mem_wdata[7:0];
            wlog_size[we_cnt[11:0]] <= bus.mem_size;
            we_cnt <= we_cnt + 1;
        end
        if (bus.mem_re && bus.mem_we) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic ref_err(input logic [1:0] s, input logic [31:0] a);
        logic [31:0] last;
        last = a + 32'(nbytes(s)) - 32'd1;
        return (s == 2'd2) || (a[31:16] != 16'h1000) || (last[31:16] != 16'h1000);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] s, input logic sg,
                                             input logic [31:0] a);
        logic [31:0] v, ai;
        int n;
        n = nbytes(s);
        v = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            v[8*i +: 8] = ref_mem[ai[15:0]];
        end
        if (sg && n < 4 && v[8*n-1]) begin
            for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] ai;
        for (int i = 0; i < nbytes(s); i++) begin
            ai = a + 32'(i);
            ref_mem[ai[15:0]] = wd[8*i +: 8];
        end
    endtask

    // One transaction, started at a negedge with req_ready high; ends at a negedge, idle.
    task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
        int n, lat_exp, nre_exp, nwe_exp;
        logic err_exp;
        logic [31:0] rd_exp;
        n       = nbytes(sz);
        err_exp = ref_err(sz, a);
        rd_exp  = (!err_exp && !we) ? ref_load(sz, sg, a) : 32'd0;
        nre_exp = 0;
        nwe_exp = 0;
        if (err_exp) begin
            lat_exp = 1;
        end else if (!we) begin
            lat_exp = (int'(a[1:0]) + n > 4) ? 3 : 2;
            nre_exp = lat_exp - 1;
        end else if (int'(a[1:0]) % n == 0) begin
            lat_exp = 2;
            nwe_exp = 1;
        end else begin
            lat_exp = n + 1;
            nwe_exp = n;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        t_rbase = re_cnt;
        t_wbase = we_cnt;
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clock);
        t_lat   = 0;
        t_rdata = 32'hxxxxxxxx;
        t_err   = 1'bx;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                t_lat   = k;
                t_rdata = bus.resp_rdata;
                t_err   = bus.resp_err;
                break;
            end
        end
        @(negedge clock);
        check({tag, ".lat"}, t_lat, lat_exp);
        check({tag, ".err"}, 32'(t_err), 32'(err_exp));
        check({tag, ".rdata"}, t_rdata, rd_exp);
        check({tag, ".nre"}, re_cnt - t_rbase, nre_exp);
        check({tag, ".nwe"}, we_cnt - t_wbase, nwe_exp);
        check({tag, ".pulse"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
        if (we && !err_exp) ref_store(sz, a, wd);
    endtask

    initial begin
        logic [7:0]  exp_b [4];
        logic [31:0] idx, a;
        logic [1:0]  sz;
        logic        saw;
        int          sel, bad;
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

        reset = 1'b0;
        load_ram = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        @(negedge clock);
        @(posedge clock);
        load_ram = 1'b0;
        @(negedge clock);
        check("rst.req_ready", 32'(bus.req_ready), 0);
        check("rst.resp_valid", 32'(bus.resp_valid), 0);
        check("rst.resp_rdata", bus.resp_rdata, 0);
        check("rst.resp_err", 32'(bus.resp_err), 0);
        check("rst.mem_we", 32'(bus.mem_we), 0);
        check("rst.mem_re", 32'(bus.mem_re), 0);
        check("rst.mem_addr", bus.mem_addr, 0);
        check("rst.mem_wdata", bus.mem_wdata, 0);
        check("rst.mem_size", 32'(bus.mem_size), 0);
        reset = 1'b1;
        @(negedge clock);

        run("st_beef", 1'b1, 2'd3, 1'b0, 32'h1000_0010, 32'hDEADBEEF);
        run("ld_word", 1'b0, 2'd3, 1'b0, 32'h1000_0010, 32'h0);
        check("ld_word.const", t_rdata, 32'hDEADBEEF);
        check("ld_word.cycle", t_lat, 2);

        run("st_8011", 1'b1, 2'd3, 1'b0, 32'h1000_0010, 32'h80112233);
        run("ld_sb", 1'b0, 2'd0, 1'b1, 32'h1000_0013, 32'h0);
        check("ld_sb.const", t_rdata, 32'hFFFFFF80);
        run("ld_ub", 1'b0, 2'd0, 1'b0, 32'h1000_0013, 32'h0);
        check("ld_ub.const", t_rdata, 32'h00000080);

        run("st_w4", 1'b1, 2'd3, 1'b0, 32'h1000_0004, 32'h44332211);
        run("st_w8", 1'b1, 2'd3, 1'b0, 32'h1000_0008, 32'h88776655);
        run("ld_cross", 1'b0, 2'd3, 1'b0, 32'h1000_0006, 32'h0);
        check("ld_cross.const", t_rdata, 32'h66554433);
        check("ld_cross.cycle", t_lat, 3);
        check("ld_cross.addr0", rlog[t_rbase[11:0]], 32'h1000_0004);
        idx = t_rbase + 1;
        check("ld_cross.addr1", rlog[idx[11:0]], 32'h1000_0008);

        run("st_w20", 1'b1, 2'd3, 1'b0, 32'h1000_0020, 32'h11111111);
        run("st_w24", 1'b1, 2'd3, 1'b0, 32'h1000_0024, 32'h22222222);
        run("st_mis", 1'b1, 2'd3, 1'b0, 32'h1000_0023, 32'hA1B2C3D4);
        check("st_mis.cycle", t_lat, 5);
        for (int i = 0; i < 4; i++) begin
            idx = t_wbase + 32'(i);
            check("st_mis.addr", wlog_addr[idx[11:0]], 32'h1000_0023 + 32'(i));
            check("st_mis.size", 32'(wlog_size[idx[11:0]]), 0);
            check("st_mis.byte", 32'(wlog_data[idx[11:0]]), 32'(exp_b[i]));
        end
        run("rb_w20", 1'b0, 2'd3, 1'b0, 32'h1000_0020, 32'h0);
        check("rb_w20.const", t_rdata, 32'hD4111111);
        run("rb_w24", 1'b0, 2'd3, 1'b0, 32'h1000_0024, 32'h0);
        check("rb_w24.const", t_rdata, 32'h22A1B2C3);

        run("err_region", 1'b0, 2'd3, 1'b0, 32'h2000_0000, 32'h0);
        check("err_region.flag", 32'(t_err), 1);
        run("err_cross", 1'b0, 2'd3, 1'b0, 32'h1000_FFFE, 32'h0);
        check("err_cross.flag", 32'(t_err), 1);
        run("err_size", 1'b0, 2'd2, 1'b0, 32'h1000_0000, 32'h0);
        check("err_size.flag", 32'(t_err), 1);

        // Reset during the second byte beat of a misaligned word store.
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'd3;
        bus.req_addr = 32'h1000_0031;
        bus.req_wdata = 32'h55667788;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (bus.resp_valid) saw = 1'b1;
        end
        check("midrst.no_resp", 32'(saw), 0);
        check("midrst.mem_we", 32'(bus.mem_we), 0);
        check("midrst.ready", 32'(bus.req_ready), 0);
        ref_mem[16'h0031] = 8'h88;
        ref_mem[16'h0032] = 8'h77;
        reset = 1'b1;
        @(negedge clock);
        run("post_rst_st", 1'b1, 2'd1, 1'b0, 32'h1000_0002, 32'h0000BEEF);
        run("post_rst_ld", 1'b0, 2'd1, 1'b0, 32'h1000_0002, 32'h0);
        check("post_rst_ld.const", t_rdata, 32'h0000BEEF);
        run("midrst_rb", 1'b0, 2'd3, 1'b0, 32'h1000_0030, 32'h0);

        for (int t = 0; t < 150; t++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = 32'h1000_0000 + $urandom_range(0, 63);
            else if (sel == 7) a = 32'h1000_FFF8 + $urandom_range(0, 7);
            else if (sel == 8) a = $urandom;
            else               a = 32'h0FFF_FFFC + $urandom_range(0, 7);
            sz = 2'($urandom_range(0, 3));
            if (sz == 2'd2 && $urandom_range(0, 1) == 1) sz = 2'd3;
            run("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        check("never_re_and_we", both_cnt, 0);
        bad = 0;
        for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) bad++;
        check("ram_image", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
